// File: rtl/ram_requester.sv
// ram_requester
//   Converts a valid/ready command stream into registered single-port RAM
//   accesses and returns read data, in issue order, through a small response
//   FIFO. Reads are credit-limited so that every read in flight is guaranteed
//   a FIFO slot; writes need no credit and produce no response.
//
// Optional feature: define RAM_REQ_BURST_EN to add cmd_len. One command then
//   produces cmd_len+1 accesses at consecutive (wrapping) addresses; a write
//   burst repeats cmd_wdata. Without the macro every command is one access.
//
// Ports
//   clock, reset          single rising-edge clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake
//   cmd_write             1 = write, 0 = read
//   cmd_addr, cmd_wdata   start word address, write data
//   cmd_len               burst length minus one (RAM_REQ_BURST_EN only)
//   rsp_valid/rsp_ready   response handshake
//   rsp_data              read data, FIFO-head register
//   ram_address, ram_wren, ram_write_data   registered RAM command
//   ram_read_data         RAM read data, READ_LAT cycles after the RAM samples
module ram_requester #(
    parameter  int WIDTH      = 8,
    parameter  int WORDS      = 2048,
    parameter  int RBUF_DEPTH = 4,
    parameter  int READ_LAT   = 2,
    localparam int ADDR_BITS  = $clog2(WORDS - 1)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [ADDR_BITS-1:0] cmd_addr,
    input  logic [WIDTH-1:0]     cmd_wdata,
`ifdef RAM_REQ_BURST_EN
    input  logic [3:0]           cmd_len,
`endif
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [WIDTH-1:0]     rsp_data,
    output logic [ADDR_BITS-1:0] ram_address,
    output logic                 ram_wren,
    output logic [WIDTH-1:0]     ram_write_data,
    input  logic [WIDTH-1:0]     ram_read_data
);

    localparam int PTR_BITS = $clog2(RBUF_DEPTH);
    localparam int CNT_BITS = PTR_BITS + 1;
    localparam logic [CNT_BITS-1:0] DEPTH_C = CNT_BITS'(RBUF_DEPTH);
    localparam logic [PTR_BITS-1:0] PTR_ONE = PTR_BITS'(1);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t state, state_n;

    logic                 issue;
    logic                 issue_write;
    logic [ADDR_BITS-1:0] issue_addr;
    logic [WIDTH-1:0]     issue_wdata;
    logic                 rd_issue;
    logic                 credit_ok;

    // Reads in flight plus FIFO occupancy.
    logic [CNT_BITS-1:0]  used;

    logic                 rd_q;
    logic [READ_LAT-1:0]  tag;
    logic                 push;
    logic                 pop;

    logic [WIDTH-1:0]     mem [RBUF_DEPTH];
    logic [PTR_BITS-1:0]  wr_ptr, rd_ptr, rd_ptr_n;
    logic [CNT_BITS-1:0]  count, count_n;
    logic [WIDTH-1:0]     next_head;

`ifdef RAM_REQ_BURST_EN
    localparam logic [ADDR_BITS-1:0] ADDR_ONE = ADDR_BITS'(1);

    logic [ADDR_BITS-1:0] b_addr;
    logic [3:0]           b_left;
    logic                 b_write;
    logic [WIDTH-1:0]     b_wdata;
`endif

    // ------------------------------------------------------------------
    // Command FSM: next state and issue selection
    // ------------------------------------------------------------------
    always_comb begin
        credit_ok   = (used < DEPTH_C);
        cmd_ready   = 1'b0;
        issue       = 1'b0;
        issue_write = cmd_write;
        issue_addr  = cmd_addr;
        issue_wdata = cmd_wdata;
        state_n     = state;
        case (state)
            IDLE: begin
                cmd_ready = !reset && (cmd_write || credit_ok);
                issue     = cmd_valid && cmd_ready;
`ifdef RAM_REQ_BURST_EN
                if (issue && (cmd_len != 4'd0)) begin
                    state_n = BURST;
                end
`endif
            end
            BURST: begin
`ifdef RAM_REQ_BURST_EN
                issue_write = b_write;
                issue_addr  = b_addr;
                issue_wdata = b_wdata;
                // Read beats wait for credit one at a time.
                issue       = !reset && (b_write || credit_ok);
                if (issue && (b_left == 4'd1)) begin
                    state_n = IDLE;
                end
`else
                state_n = IDLE;
`endif
            end
            default: state_n = IDLE;
        endcase
        rd_issue = issue && !issue_write;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

`ifdef RAM_REQ_BURST_EN
    // b_addr/b_left describe the beats still to be issued after the first.
    always_ff @(posedge clock) begin
        if (reset) begin
            b_addr  <= '0;
            b_left  <= '0;
            b_write <= 1'b0;
            b_wdata <= '0;
        end else if (issue) begin
            if (state == IDLE) begin
                b_addr  <= cmd_addr + ADDR_ONE;
                b_left  <= cmd_len;
                b_write <= cmd_write;
                b_wdata <= cmd_wdata;
            end else begin
                b_addr  <= b_addr + ADDR_ONE;
                b_left  <= b_left - 4'd1;
            end
        end
    end
`endif

    // ------------------------------------------------------------------
    // Registered RAM command; idle cycles hold address and write data
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            ram_address    <= '0;
            ram_wren       <= 1'b0;
            ram_write_data <= '0;
        end else if (issue) begin
            ram_address <= issue_addr;
            ram_wren    <= issue_write;
            if (issue_write) begin
                ram_write_data <= issue_wdata;
            end
        end else begin
            ram_wren <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Read tags: rd_q marks a read on the RAM port this cycle; the tag then
    // spends READ_LAT cycles in the shift register, matching the RAM's
    // sample-to-data latency, and its exit pushes ram_read_data.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_q <= 1'b0;
            tag  <= '0;
        end else begin
            rd_q   <= rd_issue;
            tag[0] <= rd_q;
            for (int unsigned i = 1; i < READ_LAT; i++) begin
                tag[i] <= tag[i-1];
            end
        end
    end

    assign push = tag[READ_LAT-1];
    assign pop  = rsp_valid && rsp_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            used <= '0;
        end else begin
            used <= used + CNT_BITS'(rd_issue) - CNT_BITS'(pop);
        end
    end

    // ------------------------------------------------------------------
    // Response FIFO with registered head. The head register is loaded with
    // the entry that will be at the head after this edge, bypassing the
    // incoming word when it lands directly in the head slot.
    // ------------------------------------------------------------------
    always_comb begin
        rd_ptr_n  = pop ? (rd_ptr + PTR_ONE) : rd_ptr;
        count_n   = count + CNT_BITS'(push) - CNT_BITS'(pop);
        next_head = (push && (rd_ptr_n == wr_ptr)) ? ram_read_data : mem[rd_ptr_n];
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= ram_read_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            rd_ptr    <= rd_ptr_n;
            count     <= count_n;
            rsp_valid <= (count_n != '0);
            rsp_data  <= (count_n != '0) ? next_head : '0;
        end
    end

endmodule

// File: doc/ram_requester.md
RAM_REQUESTER -- requirements
Module: ram_requester

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning data word width in bits.
REQ-002 SHALL have parameter WORDS, default 2048, meaning RAM depth; derived local ADDR_BITS = clog2(WORDS-1).
REQ-003 SHALL have parameter RBUF_DEPTH, default 4, meaning read-response buffer entries (power of 2, >= 4).
REQ-004 SHALL have parameter READ_LAT, default 2, meaning RAM cycles from ram_address/ram_wren sample to valid ram_read_data.
REQ-005 clock  input  1  single clock, all logic on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 cmd_valid  input  1  command present.
REQ-008 cmd_ready  output  1  command accepted on this edge when cmd_valid is also high.
REQ-009 cmd_write  input  1  1 = write, 0 = read.
REQ-010 cmd_addr  input  ADDR_BITS  start word address.
REQ-011 cmd_wdata  input  WIDTH  write data.
REQ-012 cmd_len  input  4  burst length minus one (present only with RAM_REQ_BURST_EN).
REQ-013 rsp_valid  output  1  read data available.
REQ-014 rsp_ready  input  1  consumer takes rsp_data on this edge when rsp_valid is also high.
REQ-015 rsp_data  output  WIDTH  read data, in issue order.
REQ-016 ram_address  output  ADDR_BITS  registered RAM address.
REQ-017 ram_wren  output  1  registered RAM write enable.
REQ-018 ram_write_data  output  WIDTH  registered RAM write data.
REQ-019 ram_read_data  input  WIDTH  RAM read data, READ_LAT cycles after issue.

Function
REQ-020 Handshake: transfer only on cmd_valid && cmd_ready; cmd_* SHALL be ignored otherwise.
REQ-021 Issue: accepted access SHALL drive ram_address/ram_wren/ram_write_data from the edge of acceptance; idle cycles SHALL drive ram_wren=0 and hold ram_address.
REQ-022 Read tracking: a READ_LAT-deep valid shift register SHALL tag each issued read; when the tag exits, ram_read_data SHALL be written into the response FIFO on that edge.
REQ-023 Latency: read accepted at edge E0 with empty FIFO and rsp_ready=1 SHALL raise rsp_valid after edge E0+READ_LAT+1, i.e. 3 cycles at default.
REQ-024 Credit: reads SHALL be issued only while (in-flight tags + FIFO occupancy) < RBUF_DEPTH; a read SHALL never be lost on backpressure.
REQ-025 Writes SHALL need no credit, produce no response, and always be accepted when the FSM is IDLE.
REQ-026 Ordering: responses SHALL return in issue order; a read issued the cycle after a write to the same address SHALL return the new data.
REQ-027 FIFO simultaneous push and pop at full SHALL be legal, with occupancy unchanged; a pop when empty SHALL be impossible (rsp_valid=0).
REQ-028 rsp_data/rsp_valid SHALL be FIFO-head registered outputs, stable while rsp_valid && !rsp_ready.
REQ-029 FSM states: IDLE (accept commands) and BURST (issue remaining beats, cmd_ready=0); BURST -> IDLE on the edge that issues the last beat.

Reset
REQ-030 Reset SHALL force cmd_ready=0 during reset and 1 the cycle after; rsp_valid=0, rsp_data=0, ram_wren=0, ram_address=0, ram_write_data=0.
REQ-031 Reset SHALL clear the tag pipeline, FIFO pointers and credit count, discard in-flight reads, and abort any burst (FSM -> IDLE).

Configuration
REQ-032 With macro RAM_REQ_BURST_EN defined, cmd_len SHALL exist; one command SHALL generate cmd_len+1 accesses at consecutive addresses wrapping modulo 2^ADDR_BITS; a write burst SHALL repeat cmd_wdata (fill); a read burst SHALL stall per beat on credit.
REQ-033 Without RAM_REQ_BURST_EN, cmd_len SHALL be absent, every command SHALL be exactly one access, and the FSM SHALL remain in IDLE.

Verification
REQ-034 Write 0xA5 to addr 0x010, then read 0x010 the next cycle -> rsp_data=0xA5 three cycles after the read is accepted.
REQ-035 Hold rsp_ready=0 and issue 6 reads -> exactly 4 accepted, cmd_ready=0 afterward; release rsp_ready -> 6 responses in order, none lost.
REQ-036 FIFO full with rsp_ready=1 and a read tag exiting on the same edge -> occupancy stays 4 and data order is preserved.
REQ-037 Assert reset with 2 reads in flight -> no rsp_valid afterward; next read returns correct data.
REQ-038 (BURST_EN) Write burst addr 0x7FE, cmd_len=3, data 0x3C -> addresses 0x7FE, 0x7FF, 0x000, 0x001 written 0x3C; cmd_ready low for 3 cycles.
REQ-039 (BURST_EN) Read burst cmd_len=7 with rsp_ready=0 -> 4 beats issued, then stall; resumes after pops, 8 ordered responses.
